// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and round-robin auto-scan.
// One sample per DWELL enabled cycles in scan mode; valid/wrap strobes mark each sample.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          s,
  input  logic                      en,
  output logic [WIDTH-1:0]          f,
  output logic [SEL_W-1:0]          ch,
  output logic                      valid,
  output logic                      wrap
);

  localparam int CNT_W                = $clog2(DWELL + 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam bit POW2                 = (CHANNELS == (1 << SEL_W));

  function automatic logic [WIDTH-1:0] pick_chan(input logic [CHANNELS*WIDTH-1:0] bus,
                                                  input logic [SEL_W-1:0]          idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) r = bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // Wraps to 0 after the last real channel, not at the next power of two.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (p == LAST_CH) ? '0 : p + SEL_W'(1);
  endfunction

  logic             s_ok;
  logic [SEL_W-1:0] ptr_q, ptr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [SEL_W-1:0] sel_p0;
  logic             take_p0;
  logic             wrap_p0;
  logic [WIDTH-1:0] f_p1;
  logic [SEL_W-1:0] ch_p1;
  logic             vld_p1;
  logic             wrap_p1;

  generate
    if (POW2) begin : g_pow2
      assign s_ok = 1'b1;
    end else begin : g_npow2
      assign s_ok = (s <= LAST_CH);
    end
  endgenerate

  always_comb begin
    ptr_nxt = ptr_q;
    cnt_nxt = cnt_q;
    sel_p0  = ptr_q;
    take_p0 = 1'b0;
    wrap_p0 = 1'b0;
    if (en) begin
      if (!mode) begin
        if (s_ok) begin
          take_p0 = 1'b1;
          sel_p0  = s;
          ptr_nxt = s;
          cnt_nxt = '0;
        end
      end else if (cnt_q == CNT_LAST) begin
        take_p0 = 1'b1;
        sel_p0  = ptr_q;
        wrap_p0 = (ptr_q == LAST_CH);
        ptr_nxt = next_ptr(ptr_q);
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt_q + CNT_W'(1);
      end
    end
  end

  // ---- p0 -> p1: register selected sample and strobes ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      f_p1    <= '0;
      ch_p1   <= '0;
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
    end else begin
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_nxt;
      vld_p1  <= take_p0;
      wrap_p1 <= wrap_p0;
      if (take_p0) begin
        f_p1  <= pick_chan(w, sel_p0);
        ch_p1 <= sel_p0;
      end
    end
  end

  assign f     = f_p1;
  assign ch    = ch_p1;
  assign valid = vld_p1;
  assign wrap  = wrap_p1;

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel multiplexer with manual-select and auto-scan modes. It extends the fixed 4-to-1 combinational selector to any channel count and width. In scan mode it steps round-robin through the channels with a programmable dwell time and marks each sample with a valid strobe and a wrap flag. It sits between banks of parallel sources (switch inputs, function-table terms, sensor lines) and a single serial consumer.

## Interface

Parameters:
- WIDTH, 1, bits per channel
- CHANNELS, 4, number of input channels (≥2; need not be a power of 2)
- DWELL, 1, enabled cycles spent on each channel in scan mode (≥1)
- SEL_W, derived as $clog2(CHANNELS), select/index width (localparam)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- w  in  CHANNELS*WIDTH  packed inputs; channel k = w[k*WIDTH +: WIDTH]
- mode  in  1  0 = manual select, 1 = auto-scan
- s  in  SEL_W  manual channel select
- en  in  1  advance/sample enable; low = hold
- f  out  WIDTH  registered selected channel data
- ch  out  SEL_W  index of channel currently presented on f
- valid  out  1  one-cycle strobe: f/ch updated this cycle with a new sample
- wrap  out  1  one-cycle strobe with valid when the scan sample was channel CHANNELS-1

## Operation

- Internal state: ptr (SEL_W, next scan channel) and cnt (dwell counter, $clog2(DWELL+1) bits).
- Reset (rst_n low, asynchronous): f=0, ch=0, valid=0, wrap=0, ptr=0, cnt=0. These values hold while rst_n is low. Reset mid-scan discards the partial dwell.
- en=0, either mode: f, ch, ptr and cnt hold; valid=0, wrap=0.
- Manual mode (mode=0, en=1):
  - s<CHANNELS: f←channel s, ch←s, valid←1, wrap←0, ptr←s, cnt←0.
  - s≥CHANNELS (out of range, only possible for non-power-of-2 CHANNELS): f and ch hold, valid←0, wrap←0, ptr and cnt unchanged.
- Scan mode (mode=1, en=1):
  - cnt<DWELL-1: cnt←cnt+1; valid←0, wrap←0; f and ch hold.
  - cnt==DWELL-1: f←channel ptr, ch←ptr, valid←1, wrap←(ptr==CHANNELS-1), cnt←0, ptr←(ptr==CHANNELS-1)?0:ptr+1.
- Mode switch manual→scan: scanning starts from the last valid manual s, with a fresh dwell because cnt=0.
- Mode switch scan→manual: takes effect on the next enabled edge. The partial dwell is discarded.
- DWELL=1: a scan sample and valid are produced on every enabled cycle.
- ptr never exceeds CHANNELS-1. Wrap-around goes to 0, never to the next power of 2.

## Timing

- Latency: f reflects w as sampled at the rising edge where valid is asserted. This is 1 cycle from input to output, with no combinational path from w to f.
- valid and wrap are registered and high for exactly one cycle per sample.
- Scan period: CHANNELS×DWELL enabled cycles per full sweep, with one wrap per sweep.
- mode, s and en are sampled on the same edge. No priority beyond the rules above.
- Asynchronous reset assertion clears outputs immediately. Deassertion is synchronised externally and is not handled in this block.

## Test plan

- Reset: drive rst_n=0 mid-scan with w nonzero → f=0, ch=0, valid=0, wrap=0 immediately. After release with mode=1, en=1, DWELL=1 → the first sample is ch=0.
- Manual (WIDTH=8, CHANNELS=4): w={8'hDD,8'hCC,8'hBB,8'hAA}, en=1, s=2 → next cycle f=8'hCC, ch=2, valid=1, wrap=0. Set en=0 → f stays 8'hCC and valid=0.
- Scan with DWELL=3, CHANNELS=4, same w: f sequence AA,BB,CC,DD,AA. valid every 3rd enabled cycle. wrap high only together with f=DD, ch=3.
- Non-power-of-2 (CHANNELS=3, DWELL=1): ch sequence 0,1,2,0 with wrap at ch=2. Manual s=3 → valid=0, and f/ch hold.
- Enable gating in scan (DWELL=2): drop en for 5 cycles mid-dwell → cnt and ptr frozen, no valid. Resume → the sample arrives after the remaining single enabled cycle.
- Mode switch: manual s=1, then mode=1 with DWELL=1 → samples ch=1,2,3,0. Switch back to manual s=0 mid-sweep → next cycle ch=0, valid=1, wrap=0.
